mem_port_arbiter: RTL

Arbitrates one single-port unified memory between the instruction fetch stage and the memory (load/store) stage of the pipelined ARM core. Each requester gets a level request/valid-pulse interface. The block produces per-stage stall signals that drive the pipeline freeze logic. It sequences a variable-latency req/ack memory bus, uses fixed data-over-fetch priority with a starvation guard, and squashes fetch responses killed by a taken branch.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_starve.sv | 33 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: FSM encoding,
// requester identifiers and the default datapath width.
package mem_port_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Starvation guard: counts MEM grants made while fetch waits and forces
// the next grant to fetch once the limit is reached.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic       if_grant,
    input  logic       mem_grant,
    output logic       force_if,
    output logic [3:0] count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (if_grant) begin
            count <= 4'd0;
        end else if (mem_grant) begin
            // A MEM grant with nobody waiting resets the fairness history.
            if (!if_req)
                count <= 4'd0;
            else if (count != LIMIT)
                count <= count + 4'd1;
        end
    end

    assign force_if = if_req && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between fetch and load/store, with
// data-over-fetch priority, a starvation guard and flush-based fetch kill.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_If_Req,
    input  logic [DATA_WIDTH-1:0] i_If_Addr,
    input  logic                  i_Flush,
    output logic [DATA_WIDTH-1:0] o_If_Rdata,
    output logic                  o_If_Valid,
    output logic                  o_If_Stall,
    input  logic                  i_Mem_Req,
    input  logic                  i_Mem_We,
    input  logic [DATA_WIDTH-1:0] i_Mem_Addr,
    input  logic [DATA_WIDTH-1:0] i_Mem_Wdata,
    output logic [DATA_WIDTH-1:0] o_Mem_Rdata,
    output logic                  o_Mem_Valid,
    output logic                  o_Mem_Stall,
    output logic                  o_Bus_Req,
    output logic                  o_Bus_We,
    output logic [DATA_WIDTH-1:0] o_Bus_Addr,
    output logic [DATA_WIDTH-1:0] o_Bus_Wdata,
    input  logic                  i_Bus_Ack,
    input  logic [DATA_WIDTH-1:0] i_Bus_Rdata,
    output logic [1:0]            dbg_state,
    output logic [3:0]            dbg_starve
);

    // Handshakes: requesters hold a level request (and its address/data)
    // until their one-cycle valid pulse; fetch may also abandon on flush.
    // The bus request is held with constant address/data until a one-cycle
    // ack, which carries read data in the same cycle.

    logic [1:0] state;
    logic       owner;
    logic       kill;
    logic       force_if;
    logic       mem_win;
    logic       if_win;
    logic       if_grant;
    logic       mem_grant;

    assign mem_win   = i_Mem_Req && !force_if;
    assign if_win    = i_If_Req && !i_Flush && !mem_win;
    assign mem_grant = (state == IDLE) && mem_win;
    assign if_grant  = (state == IDLE) && if_win;

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .if_req   (i_If_Req),
        .if_grant (if_grant),
        .mem_grant(mem_grant),
        .force_if (force_if),
        .count    (dbg_starve)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= REQ_IF;
            kill        <= 1'b0;
            o_Bus_Req   <= 1'b0;
            o_Bus_We    <= 1'b0;
            o_Bus_Addr  <= '0;
            o_Bus_Wdata <= '0;
            o_If_Rdata  <= '0;
            o_If_Valid  <= 1'b0;
            o_Mem_Rdata <= '0;
            o_Mem_Valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (mem_win) begin
                        state       <= BUSY_MEM;
                        owner       <= REQ_MEM;
                        o_Bus_Req   <= 1'b1;
                        o_Bus_We    <= i_Mem_We;
                        o_Bus_Addr  <= i_Mem_Addr;
                        o_Bus_Wdata <= i_Mem_Wdata;
                    end else if (if_win) begin
                        state       <= BUSY_IF;
                        owner       <= REQ_IF;
                        o_Bus_Req   <= 1'b1;
                        o_Bus_We    <= 1'b0;
                        o_Bus_Addr  <= i_If_Addr;
                        o_Bus_Wdata <= '0;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (state == BUSY_IF && i_Flush)
                        kill <= 1'b1;
                    if (i_Bus_Ack) begin
                        o_Bus_Req <= 1'b0;
                        state     <= RESP;
                        if (owner == REQ_IF) begin
                            o_If_Rdata <= i_Bus_Rdata;
                            // A flush in the ack cycle must also suppress the pulse.
                            o_If_Valid <= !(kill || i_Flush);
                        end else begin
                            o_Mem_Rdata <= i_Bus_Rdata;
                            o_Mem_Valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    o_If_Valid  <= 1'b0;
                    o_Mem_Valid <= 1'b0;
                    kill        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_If_Stall  = i_If_Req && !o_If_Valid;
    assign o_Mem_Stall = i_Mem_Req && !o_Mem_Valid;
    assign dbg_state   = state;

endmodule
